// File: rtl/hazard_ctrl.sv
// hazard_ctrl: fetch advance/stall/redirect decision for the 5-stage MIPS core.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   MemRead_ex            EX-stage instruction is a load
//   RegWriteAddr_ex       destination register of the EX-stage instruction
//   RsAddr_id, RtAddr_id  source fields of the ID-stage instruction
//   UsesRt_id             ID-stage instruction reads rt
//   Z                     branch taken (resolved in EX)
//   J, JR                 jump / jump-register decoded in ID
//   Halt_id               halt instruction in ID
//   Resume                leave HALT
//   ClearCnt              synchronous clear of both counters
//   PC_IFWrite            PC update enable
//   IF_IDWrite            IF/ID register enable
//   IF_IDFlush            zero the IF/ID register
//   ID_EXFlush            insert a bubble into ID/EX
//   State                 debug view of the FSM state
//   StallCount            cycles stalled or halted (saturating)
//   FlushCount            redirects taken (saturating)
//
// state | meaning
// RUN   | normal fetch, or returning after a stall/redirect
// STALL | previous cycle was a load-use stall
// FLUSH | previous cycle was a branch/jump redirect
// HALT  | fetch frozen until Resume

module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead_ex,
  input  logic [4:0]       RegWriteAddr_ex,
  input  logic [4:0]       RsAddr_id,
  input  logic [4:0]       RtAddr_id,
  input  logic             UsesRt_id,
  input  logic             Z,
  input  logic             J,
  input  logic             JR,
  input  logic             Halt_id,
  input  logic             Resume,
  input  logic             ClearCnt,
  output logic             PC_IFWrite,
  output logic             IF_IDWrite,
  output logic             IF_IDFlush,
  output logic             ID_EXFlush,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t state_q, state_d;
  logic   load_use;
  logic   inc_stall, inc_flush;

  // r0 is never a real producer, so a load targeting it cannot create a hazard.
  assign load_use = MemRead_ex && (RegWriteAddr_ex != 5'd0) &&
                    ((RegWriteAddr_ex == RsAddr_id) ||
                     (UsesRt_id && (RegWriteAddr_ex == RtAddr_id)));

  assign State = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
    if (state_q == HALT)           state_d = Resume ? RUN : HALT;
    else if (Z)                    state_d = FLUSH;
    else if (Halt_id)              state_d = HALT;
    else if (load_use)             state_d = STALL;
    else if (J || JR)              state_d = FLUSH;
    else                           state_d = RUN;
  end

  // Only HALT feeds back into the outputs; STALL and FLUSH are debug-only.
  always_comb begin
    PC_IFWrite = 1'b1;
    IF_IDWrite = 1'b1;
    IF_IDFlush = 1'b0;
    ID_EXFlush = 1'b0;
    inc_stall  = 1'b0;
    inc_flush  = 1'b0;
    if (reset) begin
      PC_IFWrite = 1'b0;
      IF_IDWrite = 1'b0;
      IF_IDFlush = 1'b1;
      ID_EXFlush = 1'b1;
    end else if (state_q == HALT) begin
      // The Resume cycle still freezes the PC and still counts as stalled.
      PC_IFWrite = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXFlush = 1'b1;
      inc_stall  = 1'b1;
    end else if (Z) begin
      // ID instruction is on the wrong path, so it loses to the branch.
      IF_IDFlush = 1'b1;
      ID_EXFlush = 1'b1;
      inc_flush  = 1'b1;
    end else if (Halt_id) begin
      PC_IFWrite = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXFlush = 1'b1;
      inc_stall  = 1'b1;
    end else if (load_use) begin
      // A JR waiting on its rs stalls here; the jump fires next cycle.
      PC_IFWrite = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXFlush = 1'b1;
      inc_stall  = 1'b1;
    end else if (J || JR) begin
      IF_IDFlush = 1'b1;
      inc_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else if (ClearCnt) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (inc_stall && (StallCount != {CNT_W{1'b1}})) StallCount <= StallCount + 1'b1;
      if (inc_flush && (FlushCount != {CNT_W{1'b1}})) FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             MemRead_ex;
  logic [4:0]       RegWriteAddr_ex, RsAddr_id, RtAddr_id;
  logic             UsesRt_id, Z, J, JR, Halt_id, Resume, ClearCnt;
  logic             PC_IFWrite, IF_IDWrite, IF_IDFlush, ID_EXFlush;
  logic [1:0]       State;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string          tag;
    logic [3:0]     ctrl;   // {PC_IFWrite, IF_IDWrite, IF_IDFlush, ID_EXFlush}
    logic [1:0]     st;     // State after the edge
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  exp_t sb[$];

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .MemRead_ex(MemRead_ex), .RegWriteAddr_ex(RegWriteAddr_ex),
    .RsAddr_id(RsAddr_id), .RtAddr_id(RtAddr_id), .UsesRt_id(UsesRt_id),
    .Z(Z), .J(J), .JR(JR), .Halt_id(Halt_id), .Resume(Resume), .ClearCnt(ClearCnt),
    .PC_IFWrite(PC_IFWrite), .IF_IDWrite(IF_IDWrite),
    .IF_IDFlush(IF_IDFlush), .ID_EXFlush(ID_EXFlush),
    .State(State), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    MemRead_ex = 0; RegWriteAddr_ex = 0; RsAddr_id = 0; RtAddr_id = 0;
    UsesRt_id = 0; Z = 0; J = 0; JR = 0; Halt_id = 0; Resume = 0; ClearCnt = 0;
  endtask

  // Called at a negedge with inputs already driven: queue the expectation,
  // check the combinational controls, then the registered results after the edge.
  task automatic step(input string tag, input logic [3:0] ctrl, input logic [1:0] st,
                      input int stall, input int flush);
    exp_t e, g;
    e.tag = tag; e.ctrl = ctrl; e.st = st;
    e.stall = CNT_W'(stall); e.flush = CNT_W'(flush);
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    chk({g.tag, ".ctrl"}, {PC_IFWrite, IF_IDWrite, IF_IDFlush, ID_EXFlush}, g.ctrl);
    @(posedge clk); #1;
    chk({g.tag, ".state"}, State, g.st);
    chk({g.tag, ".stall"}, StallCount, g.stall);
    chk({g.tag, ".flush"}, FlushCount, g.flush);
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1; Z = 1; Halt_id = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.ctrl", {PC_IFWrite, IF_IDWrite, IF_IDFlush, ID_EXFlush}, 4'b0011);
    chk("reset.state", State, 2'b00);
    chk("reset.stall", StallCount, 0);
    chk("reset.flush", FlushCount, 0);
    reset = 0; idle();
    step("post_reset", 4'b1100, 2'b00, 0, 0);

    // load-use on rs
    MemRead_ex = 1; RegWriteAddr_ex = 8; RsAddr_id = 8;
    step("lu_rs", 4'b0001, 2'b01, 1, 0);
    idle();
    step("lu_after", 4'b1100, 2'b00, 1, 0);
    // load to r0 never stalls
    MemRead_ex = 1; RegWriteAddr_ex = 0; RsAddr_id = 0;
    step("lu_r0", 4'b1100, 2'b00, 1, 0);
    // rt match but rt unused
    MemRead_ex = 1; RegWriteAddr_ex = 8; RsAddr_id = 3; RtAddr_id = 8; UsesRt_id = 0;
    step("lu_rt_unused", 4'b1100, 2'b00, 1, 0);
    UsesRt_id = 1;
    step("lu_rt_used", 4'b0001, 2'b01, 2, 0);
    idle();
    MemRead_ex = 0; RegWriteAddr_ex = 8; RsAddr_id = 8;
    step("no_load", 4'b1100, 2'b00, 2, 0);

    // branch beats jump and load-use
    idle(); Z = 1; J = 1; MemRead_ex = 1; RegWriteAddr_ex = 8; RsAddr_id = 8;
    step("branch_prio", 4'b1111, 2'b10, 2, 1);
    idle();
    step("after_branch", 4'b1100, 2'b00, 2, 1);
    J = 1;
    step("jump", 4'b1110, 2'b10, 2, 2);
    // JR waiting on a load: stall, then jump
    idle(); JR = 1; MemRead_ex = 1; RegWriteAddr_ex = 5; RsAddr_id = 5;
    step("jr_stall", 4'b0001, 2'b01, 3, 2);
    MemRead_ex = 0;
    step("jr_take", 4'b1110, 2'b10, 3, 3);
    idle();
    step("after_jr", 4'b1100, 2'b00, 3, 3);

    // HALT: entry + 4 idle + resume = 6 frozen cycles
    Halt_id = 1;
    step("halt_enter", 4'b0001, 2'b11, 4, 3);
    idle();
    step("halt_1", 4'b0001, 2'b11, 5, 3);
    Z = 1; J = 1;
    step("halt_2_z", 4'b0001, 2'b11, 6, 3);
    idle();
    step("halt_3", 4'b0001, 2'b11, 7, 3);
    step("halt_4", 4'b0001, 2'b11, 8, 3);
    Resume = 1;
    step("halt_resume", 4'b0001, 2'b00, 9, 3);
    Resume = 0;
    step("halt_exit", 4'b1100, 2'b00, 9, 3);
    Resume = 1;
    step("resume_ignored", 4'b1100, 2'b00, 9, 3);

    // clear beats increment
    idle(); ClearCnt = 1; J = 1;
    step("clear_j", 4'b1110, 2'b10, 0, 0);
    ClearCnt = 0;
    for (int i = 1; i <= 20; i++)
      step($sformatf("jsat_%0d", i), 4'b1110, 2'b10, 0, (i > 15) ? 15 : i);

    idle(); Halt_id = 1;
    step("hsat_enter", 4'b0001, 2'b11, 1, 15);
    idle();
    for (int k = 2; k <= 17; k++)
      step($sformatf("hsat_%0d", k), 4'b0001, 2'b11, (k > 15) ? 15 : k, 15);

    // async reset while halted
    #3 reset = 1;
    #1;
    chk("async_rst.state", State, 2'b00);
    chk("async_rst.ctrl", {PC_IFWrite, IF_IDWrite, IF_IDFlush, ID_EXFlush}, 4'b0011);
    chk("async_rst.stall", StallCount, 0);
    chk("async_rst.flush", FlushCount, 0);
    @(negedge clk);
    reset = 0;
    step("after_async_rst", 4'b1100, 2'b00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
